// File: rtl/pipe_cond_pkg.sv
// Shared types for the condition/flag unit: NZCV flag layout, ARM condition codes and their evaluation.
package pipe_cond_pkg;

    localparam int FLAG_W = 4;

    typedef struct packed {
        logic N;
        logic Z;
        logic C;
        logic V;
    } flags_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    function automatic logic cond_eval(cond_e cond, flags_t f);
        logic r_pass;
        r_pass = 1'b0;
        case (cond)
            EQ: r_pass = f.Z;
            NE: r_pass = ~f.Z;
            CS: r_pass = f.C;
            CC: r_pass = ~f.C;
            MI: r_pass = f.N;
            PL: r_pass = ~f.N;
            VS: r_pass = f.V;
            VC: r_pass = ~f.V;
            HI: r_pass = ~f.Z & f.C;
            LS: r_pass = f.Z | ~f.C;
            GE: r_pass = ~(f.N ^ f.V);
            LT: r_pass = f.N ^ f.V;
            GT: r_pass = ~(f.N ^ f.V) & ~f.Z;
            LE: r_pass = (f.N ^ f.V) | f.Z;
            AL: r_pass = 1'b1;
            default: r_pass = 1'b0;
        endcase
        return r_pass;
    endfunction

endpackage

// File: rtl/pipe_cond_unit_if.sv
// Execute-stage bus of the condition unit; master = pipeline side, slave = condition unit.
interface pipe_cond_unit_if #(
    parameter int NUM_CTX   = 2,
    parameter int FW_GROUPS = 2,
    parameter int PERF_W    = 16
);
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    logic                   ValidE;
    logic [CTX_W-1:0]       CtxE;
    logic [3:0]             CondE;
    logic [3:0]             ALUFlagsE;
    logic [FW_GROUPS-1:0]   FlagWriteE;
    logic                   StallE;
    logic                   FlushE;
    logic                   CondExE;
    logic                   CondExM;
    logic                   ValidM;
    logic [4*NUM_CTX-1:0]   FlagsOut;
    logic [PERF_W-1:0]      ExecCnt;
    logic [PERF_W-1:0]      SquashCnt;

    modport master (
        output ValidE, CtxE, CondE, ALUFlagsE, FlagWriteE, StallE, FlushE,
        input  CondExE, CondExM, ValidM, FlagsOut, ExecCnt, SquashCnt
    );

    modport slave (
        input  ValidE, CtxE, CondE, ALUFlagsE, FlagWriteE, StallE, FlushE,
        output CondExE, CondExM, ValidM, FlagsOut, ExecCnt, SquashCnt
    );

endinterface

// File: rtl/pipe_cond_bank.sv
// One NZCV flag register; each FlagWrite group enables its own subset of the four flags.
module pipe_cond_bank
    import pipe_cond_pkg::*;
#(
    parameter int FW_GROUPS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [FW_GROUPS-1:0] i_grp_we,
    input  logic [FLAG_W-1:0]    i_flags,
    output logic [FLAG_W-1:0]    o_flags
);
    logic [FLAG_W-1:0] w_mask;
    logic [FLAG_W-1:0] r_flags;

    // Two groups pair the flags as {N,Z} and {C,V}; four groups map one bit per flag.
    generate
        if (FW_GROUPS == 4) begin : g_fw4
            assign w_mask = i_grp_we;
        end else begin : g_fw2
            assign w_mask = {{2{i_grp_we[1]}}, {2{i_grp_we[0]}}};
        end
    endgenerate

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (i_we) begin
            r_flags <= (r_flags & ~w_mask) | (i_flags & w_mask);
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/pipe_cond_unit.sv
// Multi-context condition unit: per-context NZCV banks, Execute condition check, Memory-stage register.
// Optional saturating exec/squash counters are built when PIPE_COND_PERF_EN is defined.
module pipe_cond_unit
    import pipe_cond_pkg::*;
#(
    parameter int NUM_CTX   = 2,
    parameter int FW_GROUPS = 2,
    parameter int PERF_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_cond_unit_if.slave  bus
);
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    logic [FLAG_W-1:0] w_bank [NUM_CTX];
    flags_t            w_sel_flags;
    logic              w_ctx_hit;
    logic              w_live;
    logic              w_cond_pass;
    logic              w_commit;
    logic              r_cond_ex_m;
    logic              r_valid_m;

    // NOTE: defaults come first so no path through the loop can infer a latch.
    always_comb begin
        w_sel_flags = '0;
        w_ctx_hit   = 1'b0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.CtxE == CTX_W'(i)) begin
                w_sel_flags = flags_t'(w_bank[i]);
                w_ctx_hit   = 1'b1;
            end
        end
    end

    // A context id beyond NUM_CTX never matches a bank, so it evaluates false and commits nothing.
    assign w_live      = bus.ValidE & ~bus.FlushE & w_ctx_hit;
    assign w_cond_pass = w_live & cond_eval(cond_e'(bus.CondE), w_sel_flags);
    assign w_commit    = w_cond_pass & ~bus.StallE;
    assign bus.CondExE = w_cond_pass;

    generate
        for (genvar g = 0; g < NUM_CTX; g++) begin : g_bank
            pipe_cond_bank #(.FW_GROUPS(FW_GROUPS)) u_bank (
                .clk      (clk),
                .reset    (reset),
                .i_we     (w_commit && (bus.CtxE == CTX_W'(g))),
                .i_grp_we (bus.FlagWriteE),
                .i_flags  (bus.ALUFlagsE),
                .o_flags  (w_bank[g])
            );
            assign bus.FlagsOut[FLAG_W*g +: FLAG_W] = w_bank[g];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond_ex_m <= 1'b0;
            r_valid_m   <= 1'b0;
        end else if (!bus.StallE) begin
            r_cond_ex_m <= w_cond_pass;
            r_valid_m   <= bus.ValidE & ~bus.FlushE;
        end
    end

    assign bus.CondExM = r_cond_ex_m;
    assign bus.ValidM  = r_valid_m;

`ifdef PIPE_COND_PERF_EN
    logic              w_count_en;
    logic [PERF_W-1:0] r_exec_cnt;
    logic [PERF_W-1:0] r_squash_cnt;

    assign w_count_en = w_live & ~bus.StallE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (w_count_en) begin
            if (w_cond_pass) begin
                if (r_exec_cnt != '1) r_exec_cnt <= r_exec_cnt + 1'b1;
            end else begin
                if (r_squash_cnt != '1) r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign bus.ExecCnt   = r_exec_cnt;
    assign bus.SquashCnt = r_squash_cnt;
`else
    assign bus.ExecCnt   = '0;
    assign bus.SquashCnt = '0;
`endif

endmodule
